wave_analyzer: RTL



---
 rtl/wave_pkg.sv | 13 +
 rtl/wave_analyzer_if.sv | 10 +
 rtl/wave_period_counter.sv | 70 +++++++
 rtl/wave_analyzer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the triangle-wave generator and its receive-side analyzer.
package wave_pkg;

  localparam int WAVE_WIDTH    = 5;
  localparam int WAVE_PERIOD_W = 8;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    RISE    = 2'd1,
    FALL    = 2'd2
  } wave_state_e;

endpackage

// File: rtl/wave_analyzer_if.sv
// Wave bus: sample qualifier plus sample, driven by the generator and consumed by the analyzer.
interface wave_analyzer_if #(
  parameter int WIDTH = wave_pkg::WAVE_WIDTH
);
  logic             en;
  logic [WIDTH-1:0] wave;

  modport master (output en, output wave);
  modport slave  (input  en, input  wave);
endinterface

// File: rtl/wave_period_counter.sv
// Trough-to-trough period counter with saturation flag and equal-period lock tracking.
module wave_period_counter
  import wave_pkg::*;
#(
  parameter int PERIOD_W = WAVE_PERIOD_W,
  parameter int LOCK_CNT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                count_en,
  input  logic                trough,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                period_ovf,
  output logic                locked
);

  localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt;
  logic [GOOD_W-1:0]   good;
  logic [GOOD_W-1:0]   good_upd;
  logic                seen_trough;

  // A saturated measurement cannot be trusted, so it restarts the run from zero.
  always_comb begin
    if (period_ovf)          good_upd = '0;
    else if (cnt == period)  good_upd = (good == GOOD_MAX) ? good : good + 1'b1;
    else                     good_upd = GOOD_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      good         <= '0;
      seen_trough  <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ovf   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (clear) begin
        cnt         <= '0;
        good        <= '0;
        seen_trough <= 1'b0;
        locked      <= 1'b0;
      end else if (trough) begin
        if (seen_trough) begin
          period       <= cnt;
          period_valid <= 1'b1;
          good         <= good_upd;
          locked       <= (good_upd >= GOOD_MAX);
        end
        seen_trough <= 1'b1;
        cnt         <= CNT_ONE;
        period_ovf  <= 1'b0;
      end else if (count_en && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX - 1'b1) period_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Receive-side triangle-wave monitor: slope tracking, peak/trough capture, period lock, step errors.
// Optional amplitude output enabled by defining WAVE_ANALYZER_AMP_EN.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int WIDTH    = WAVE_WIDTH,
  parameter int PERIOD_W = WAVE_PERIOD_W,
  parameter int MAX_STEP = 1,
  parameter int LOCK_CNT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  wave_analyzer_if.slave      bus,
  output logic                rising,
  output logic                peak_pulse,
  output logic                trough_pulse,
  output logic [WIDTH-1:0]    peak_val,
  output logic [WIDTH-1:0]    trough_val,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                period_ovf,
  output logic                step_err,
  output logic                locked,
  output logic [WIDTH-1:0]    amp
);

  localparam logic signed [WIDTH:0] STEP_LIM = (WIDTH + 1)'(MAX_STEP);

  wave_state_e           state, state_next;
  logic [WIDTH-1:0]      prev;
  logic                  have_prev;
  logic signed [WIDTH:0] delta;
  logic                  sample_ok, step_big, is_pos, is_neg;
  logic                  step_evt, peak_evt, trough_evt, count_en;

  // One extra bit keeps the difference of two unsigned samples exact.
  assign delta     = $signed({1'b0, bus.wave}) - $signed({1'b0, prev});
  assign is_neg    = delta[WIDTH];
  assign is_pos    = !delta[WIDTH] && (delta != '0);
  assign step_big  = (delta > STEP_LIM) || (delta < -STEP_LIM);
  assign sample_ok = bus.en && have_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACQUIRE;
    else        state <= state_next;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    step_evt   = 1'b0;
    peak_evt   = 1'b0;
    trough_evt = 1'b0;
    count_en   = 1'b0;
    if (sample_ok) begin
      if (step_big) begin
        step_evt   = 1'b1;
        state_next = ACQUIRE;
      end else begin
        count_en = (state != ACQUIRE);
        unique case (state)
          ACQUIRE: begin
            if (is_pos)      state_next = RISE;
            else if (is_neg) state_next = FALL;
          end
          RISE: if (is_neg) begin
            peak_evt   = 1'b1;
            state_next = FALL;
          end
          FALL: if (is_pos) begin
            trough_evt = 1'b1;
            state_next = RISE;
          end
          default: state_next = ACQUIRE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev         <= '0;
      have_prev    <= 1'b0;
      rising       <= 1'b0;
      peak_pulse   <= 1'b0;
      trough_pulse <= 1'b0;
      step_err     <= 1'b0;
      peak_val     <= '0;
      trough_val   <= '0;
    end else begin
      peak_pulse   <= peak_evt;
      trough_pulse <= trough_evt;
      step_err     <= step_evt;
      if (bus.en) begin
        prev      <= bus.wave;
        have_prev <= 1'b1;
      end
      if (sample_ok && !step_big && state_next != state) rising <= (state_next == RISE);
      if (peak_evt)   peak_val   <= prev;
      if (trough_evt) trough_val <= prev;
    end
  end

`ifdef WAVE_ANALYZER_AMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)          amp <= '0;
    else if (trough_evt) amp <= peak_val - prev;
  end
`else
  assign amp = '0;
`endif

  wave_period_counter #(
    .PERIOD_W (PERIOD_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_period (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (step_evt),
    .count_en     (count_en),
    .trough       (trough_evt),
    .period       (period),
    .period_valid (period_valid),
    .period_ovf   (period_ovf),
    .locked       (locked)
  );

endmodule
